// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit 7-segment display.
// Latency: all outputs are registered; a new value is shown from the first BLANK slot of the frame after its commit.
// Backpressure: load_ready = !pending; one shadowed value may wait for the next frame boundary (or commits at once in IDLE).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = scan, 0 = dark and idle
//   load_valid/ready    handshake for load_data (digit i at [4i+3:4i])
//   nib                 nibble to the shared segment decoder
//   dig_en              one-hot active-high digit enable
//   frame_done          one-cycle pulse in the last cycle of the last digit's slot
// Optional build macro SEG_SCAN_LZB_EN: leading-zero blanking (digit 0 always lit).
module seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_data,
  output logic              load_ready,
  output logic [3:0]        nib,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_done
);

  localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [3:0]        nib_q, nib_d;
  logic [NDIG-1:0]   dig_en_q, dig_en_d;
  logic              frame_done_q, frame_done_d;

  logic              xfer;
  logic              commit;
  logic [NDIG-1:0]   lit;

  // Next-state sequencing and shadow/active handoff.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    commit  = 1'b0;
    xfer    = load_valid && !pending_q;

    case (state_q)
      ST_IDLE: begin
        commit = pending_q;
        if (enable) begin
          state_d = ST_BLANK;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (timer_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            commit = pending_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase

    // Disable wins over everything; a frame cut short does not commit,
    // the pending value is picked up by the IDLE commit one cycle later.
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      timer_d = '0;
      commit  = pending_q && (state_q == ST_IDLE);
    end

    active_d  = commit ? shadow_q : active_q;
    shadow_d  = xfer ? load_data : shadow_q;
    // commit needs pending=1 and xfer needs pending=0, so they never coincide.
    pending_d = commit ? 1'b0 : (xfer ? 1'b1 : pending_q);
  end

  // Which digits may light, evaluated on the value that will be displayed.
`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    lit = '0;
    for (int i = 0; i < NDIG; i++) begin
      lit[i] = (i == 0) || ((active_d >> (4 * i)) != '0);
    end
  end
`else
  always_comb begin
    lit = '1;
  end
`endif

  // Outputs are computed from the next state so they are registered
  // yet line up with the state they describe.
  always_comb begin
    nib_d        = '0;
    dig_en_d     = '0;
    frame_done_d = 1'b0;
    if (state_d != ST_IDLE) begin
      nib_d = active_d[4*idx_d +: 4];
    end
    if (state_d == ST_SHOW) begin
      dig_en_d     = lit[idx_d] ? (NDIG'(1) << idx_d) : '0;
      frame_done_d = (idx_d == IDX_LAST) && (timer_d == DWELL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      nib_q        <= '0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      nib_q        <= nib_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = !pending_q;
  assign nib        = nib_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (NDIG=4, DWELL=4, BLANK=2).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: load_ready checked every frame cycle against the expected pending window.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = NDIG * SLOT;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  nib;
  logic [3:0]  dig_en;
  logic        frame_done;

  int n_cmp;
  int n_bad;

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .nib        (nib),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_lit(input logic [15:0] d, input int s);
`ifdef SEG_SCAN_LZB_EN
    logic [15:0] up;
    up = d >> (4 * s);
    return (s == 0) || (up != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  // Check ncyc cycles of a frame showing 'data', starting at frame cycle 1.
  // If ld_cyc != 0, ld_val is offered for one edge at the end of that cycle.
  task automatic run_frame(input logic [15:0] data, input int ncyc,
                           input int ld_cyc, input logic [15:0] ld_val);
    logic [3:0] e_nib;
    logic [3:0] e_en;
    int slot, pos;
    for (int c = 0; c < ncyc; c++) begin
      slot  = c / SLOT;
      pos   = c % SLOT;
      e_nib = data[4*slot +: 4];
      e_en  = (pos < BLANK || !exp_lit(data, slot)) ? 4'b0000 : (4'b0001 << slot);
      check_val($sformatf("c%0d_nib", c + 1), 32'(nib), 32'(e_nib));
      check_val($sformatf("c%0d_dig_en", c + 1), 32'(dig_en), 32'(e_en));
      check_val($sformatf("c%0d_frame_done", c + 1), 32'(frame_done), 32'(c == FRAME - 1));
      check_val($sformatf("c%0d_load_ready", c + 1), 32'(load_ready),
                32'(!(ld_cyc != 0 && (c + 1) > ld_cyc)));
      if (ld_cyc != 0 && (c + 1) == ld_cyc) begin
        load_valid = 1'b1;
        load_data  = ld_val;
      end
      tick();
      load_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b1;
    enable     = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hABCD;
    #1 rst_n = 1'b0;

    // Reset holds everything at reset values, even with enable and load offered.
    tick();
    tick();
    check_val("rst_nib", 32'(nib), 32'h0);
    check_val("rst_dig_en", 32'(dig_en), 32'h0);
    check_val("rst_frame_done", 32'(frame_done), 32'h0);
    check_val("rst_load_ready", 32'(load_ready), 32'h1);
    enable     = 1'b0;
    load_valid = 1'b0;
    rst_n      = 1'b1;
    tick();
    check_val("post_rst_load_ready", 32'(load_ready), 32'h1);
    check_val("post_rst_nib", 32'(nib), 32'h0);

    // Load in IDLE: ready drops one cycle, then the IDLE commit frees it.
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_valid = 1'b0;
    check_val("idle_load_ready_lo", 32'(load_ready), 32'h0);
    tick();
    check_val("idle_load_ready_hi", 32'(load_ready), 32'h1);
    check_val("idle_dig_en", 32'(dig_en), 32'h0);

    // Scan two frames of 0x1234; second one takes 0x5678 at cycle 7.
    enable = 1'b1;
    tick();
    run_frame(16'h1234, FRAME, 0, 16'h0);
    run_frame(16'h1234, FRAME, 7, 16'h5678);

    // New value from the very first cycle of the next frame; drop enable in SHOW of digit 2.
    run_frame(16'h5678, 15, 0, 16'h0);
    check_val("pre_drop_dig_en", 32'(dig_en), 32'h4);
    enable = 1'b0;
    tick();
    check_val("drop_dig_en", 32'(dig_en), 32'h0);
    check_val("drop_nib", 32'(nib), 32'h0);
    check_val("drop_frame_done", 32'(frame_done), 32'h0);
    tick();
    check_val("idle_dig_en2", 32'(dig_en), 32'h0);
    enable = 1'b1;
    tick();
    run_frame(16'h5678, FRAME, 0, 16'h0);

    // Async reset in the middle of a pending handshake.
    load_valid = 1'b1;
    load_data  = 16'h9ABC;
    tick();
    load_valid = 1'b0;
    check_val("hs_load_ready_lo", 32'(load_ready), 32'h0);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_nib", 32'(nib), 32'h0);
    check_val("arst_dig_en", 32'(dig_en), 32'h0);
    check_val("arst_frame_done", 32'(frame_done), 32'h0);
    check_val("arst_load_ready", 32'(load_ready), 32'h1);
    tick();
    enable = 1'b0;
    rst_n  = 1'b1;
    tick();
    check_val("arst_rel_load_ready", 32'(load_ready), 32'h1);
    enable = 1'b1;
    tick();
    run_frame(16'h0000, FRAME, 0, 16'h0);

    // Leading-zero pattern 0x0070.
    enable = 1'b0;
    tick();
    load_valid = 1'b1;
    load_data  = 16'h0070;
    tick();
    load_valid = 1'b0;
    check_val("lzb_load_ready_lo", 32'(load_ready), 32'h0);
    tick();
    check_val("lzb_load_ready_hi", 32'(load_ready), 32'h1);
    enable = 1'b1;
    tick();
    run_frame(16'h0070, FRAME, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
